// File: rtl/cc_branch_unit_pkg.sv
// Shared types for the NZP condition-code unit: FSM encodings, CC reset value, flag bit positions.
// Pure definitions; no timing or flow control of its own.
package cc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EVAL = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    localparam logic [2:0] CC_RESET = 3'b010;

    localparam int NZP_N = 2;
    localparam int NZP_Z = 1;
    localparam int NZP_P = 0;

    // Callers pass the MSB and a zero test so this stays independent of data width.
    function automatic logic [2:0] nzp_of(input logic sign, input logic is_zero);
        logic [2:0] r;
        r = '0;
        if (is_zero) begin
            r[NZP_Z] = 1'b1;
        end else if (sign) begin
            r[NZP_N] = 1'b1;
        end else begin
            r[NZP_P] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cc_branch_unit_if.sv
// Write-back, branch-request and PC-load handshake bundle between pipeline, branch unit and fetch.
// Valid/ready on the branch and PC-load paths; write-back is fire-and-forget.
interface cc_branch_unit_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int CTX_W  = 1
);
    logic              wb_valid_in;
    logic [DATA_W-1:0] wb_data_in;
    logic [CTX_W-1:0]  wb_ctx_in;

    logic              br_valid_in;
    logic              br_ready_out;
    logic [2:0]        br_mask_in;
    logic [CTX_W-1:0]  br_ctx_in;
    logic [ADDR_W-1:0] br_target_in;

    logic              pc_ld_valid_out;
    logic              pc_ld_ready_in;
    logic              pc_ld_taken_out;
    logic [ADDR_W-1:0] pc_target_out;

    modport master (
        output wb_valid_in, wb_data_in, wb_ctx_in,
        output br_valid_in, br_mask_in, br_ctx_in, br_target_in,
        output pc_ld_ready_in,
        input  br_ready_out, pc_ld_valid_out, pc_ld_taken_out, pc_target_out
    );

    modport slave (
        input  wb_valid_in, wb_data_in, wb_ctx_in,
        input  br_valid_in, br_mask_in, br_ctx_in, br_target_in,
        input  pc_ld_ready_in,
        output br_ready_out, pc_ld_valid_out, pc_ld_taken_out, pc_target_out
    );
endinterface

// File: rtl/cc_branch_unit_nzp_gen.sv
// Combinational NZP flag generator for a DATA_W-bit value; output is always one-hot.
// Zero latency, no flow control.
module cc_nzp_gen
    import cc_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] data_in,
    output logic [2:0]        nzp_out
);

    assign nzp_out = nzp_of(data_in[DATA_W-1], data_in == '0);

endmodule

// File: rtl/cc_branch_unit.sv
// Per-context NZP CC file plus branch resolver; 2-cycle accept-to-result (1 with CC_BRANCH_FORWARD_EN).
// One branch in flight: br_ready_out low from accept until the PC-load result is taken by fetch.
module cc_branch_unit
    import cc_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int NUM_CTX = 1,
    parameter int CTX_W   = 1,
    parameter int CNT_W   = 8
) (
    input  logic                 clka,
    input  logic                 reset_n_in,
    cc_branch_unit_if.slave      bus,
    output logic [3*NUM_CTX-1:0] cc_out,
    output logic [1:0]           state_out,
    output logic [CNT_W-1:0]     taken_cnt_out
);

    state_e               state_q, state_d;
    logic [3*NUM_CTX-1:0] cc_q, cc_d;
    logic [2:0]           mask_q, mask_d;
    logic [CTX_W-1:0]     ctx_q, ctx_d;
    logic [ADDR_W-1:0]    target_q, target_d;
    logic                 taken_q, taken_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           wb_nzp;

    cc_nzp_gen #(.DATA_W(DATA_W)) u_nzp_gen (
        .data_in (bus.wb_data_in),
        .nzp_out (wb_nzp)
    );

    // Out-of-range contexts select 3'b000, which makes any mask resolve not-taken.
    function automatic logic [2:0] cc_sel(input logic [3*NUM_CTX-1:0] cc,
                                          input logic [CTX_W-1:0]     ctx);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < NUM_CTX; i++) begin
            if (32'(ctx) == 32'(i)) begin
                r = cc[3*i +: 3];
            end
        end
        return r;
    endfunction

    always_comb begin
        cc_d = cc_q;
        for (int i = 0; i < NUM_CTX; i++) begin
            if (bus.wb_valid_in && (32'(bus.wb_ctx_in) == 32'(i))) begin
                cc_d[3*i +: 3] = wb_nzp;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        ctx_d    = ctx_q;
        target_d = target_q;
        taken_d  = taken_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.br_valid_in) begin
                    target_d = bus.br_target_in;
                    mask_d   = bus.br_mask_in;
                    ctx_d    = bus.br_ctx_in;
`ifdef CC_BRANCH_FORWARD_EN
                    // cc_d already carries this cycle's write-back, giving the bypass.
                    taken_d  = |(bus.br_mask_in & cc_sel(cc_d, bus.br_ctx_in));
                    state_d  = ST_RESP;
`else
                    state_d  = ST_EVAL;
`endif
                end
            end
            ST_EVAL: begin
                taken_d = |(mask_q & cc_sel(cc_q, ctx_q));
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bus.pc_ld_ready_in) begin
                    state_d = ST_IDLE;
                    if (taken_q) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        if (!reset_n_in) begin
            state_q  <= ST_IDLE;
            cc_q     <= {NUM_CTX{CC_RESET}};
            mask_q   <= '0;
            ctx_q    <= '0;
            target_q <= '0;
            taken_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            cc_q     <= cc_d;
            mask_q   <= mask_d;
            ctx_q    <= ctx_d;
            target_q <= target_d;
            taken_q  <= taken_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.br_ready_out    = (state_q == ST_IDLE);
    assign bus.pc_ld_valid_out = (state_q == ST_RESP);
    assign bus.pc_ld_taken_out = taken_q;
    assign bus.pc_target_out   = target_q;
    assign cc_out              = cc_q;
    assign state_out           = state_q;
    assign taken_cnt_out       = cnt_q;

endmodule

// File: tb/tb_cc_branch_unit.sv
// Directed bench for cc_branch_unit (4 contexts, 3-bit ctx, 2-bit counter) with a transaction-level model.
// Expected result latency follows CC_BRANCH_FORWARD_EN.
module tb_cc_branch_unit;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 16;
    localparam int NUM_CTX = 4;
    localparam int CTX_W   = 3;
    localparam int CNT_W   = 2;
`ifdef CC_BRANCH_FORWARD_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic clka = 1'b0;
    logic reset_n_in;
    logic [3*NUM_CTX-1:0] cc_out;
    logic [1:0]           state_out;
    logic [CNT_W-1:0]     taken_cnt_out;

    always #5 clka = ~clka;

    cc_branch_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTX_W(CTX_W)) bus ();

    cc_branch_unit #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CTX(NUM_CTX), .CTX_W(CTX_W), .CNT_W(CNT_W)
    ) dut (
        .clka          (clka),
        .reset_n_in    (reset_n_in),
        .bus           (bus.slave),
        .cc_out        (cc_out),
        .state_out     (state_out),
        .taken_cnt_out (taken_cnt_out)
    );

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    // Model: CC values per context, one outstanding branch with its accept cycle.
    logic [2:0]        cc_m [NUM_CTX];
    int                cnt_m = 0;
    bit                busy = 1'b0;
    bit                exp_taken = 1'b0;
    logic [ADDR_W-1:0] exp_target = '0;
    int                acc_cyc = 0;
    int                cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [2:0] nzp(input logic [DATA_W-1:0] d);
        if (d == 0) return 3'b010;
        if (d >= 16'h8000) return 3'b100;
        return 3'b001;
    endfunction

    function automatic bit exp_valid();
        return busy && (cyc >= acc_cyc + LAT);
    endfunction

    always @(posedge clka) begin
        logic [2:0] nxt [NUM_CTX];
        int wc, bc;
        if (!reset_n_in) begin
            for (int i = 0; i < NUM_CTX; i++) cc_m[i] = 3'b010;
            cnt_m = 0;
            busy  = 1'b0;
        end else begin
            nxt = cc_m;
            wc  = int'(bus.wb_ctx_in);
            bc  = int'(bus.br_ctx_in);
            if (bus.wb_valid_in && wc < NUM_CTX) nxt[wc] = nzp(bus.wb_data_in);
            if (busy) begin
                if (exp_valid() && bus.pc_ld_ready_in) begin
                    busy = 1'b0;
                    if (exp_taken) cnt_m = (cnt_m + 1) % (1 << CNT_W);
                end
            end else if (bus.br_valid_in) begin
                busy       = 1'b1;
                acc_cyc    = cyc;
                exp_target = bus.br_target_in;
                exp_taken  = (bc < NUM_CTX) && ((bus.br_mask_in & nxt[bc]) != 3'b000);
            end
            cc_m = nxt;
        end
        cyc++;
    end

    always @(negedge clka) begin
        if (mon_en) begin
            logic [3*NUM_CTX-1:0] ecc;
            for (int i = 0; i < NUM_CTX; i++) ecc[3*i +: 3] = cc_m[i];
            chk("cc_file", 64'(cc_out), 64'(ecc));
            chk("taken_cnt", 64'(taken_cnt_out), 64'(cnt_m));
            chk("pc_ld_valid", 64'(bus.pc_ld_valid_out), 64'(exp_valid()));
            chk("br_ready", 64'(bus.br_ready_out), 64'(!busy));
            chk("state", 64'(state_out), !busy ? 64'd0 : (exp_valid() ? 64'd2 : 64'd1));
            if (exp_valid()) begin
                chk("pc_ld_taken", 64'(bus.pc_ld_taken_out), 64'(exp_taken));
                chk("pc_target", 64'(bus.pc_target_out), 64'(exp_target));
            end
        end
    end

    task automatic wb1(input int ctx, input logic [DATA_W-1:0] dat);
        bus.wb_valid_in = 1'b1;
        bus.wb_ctx_in   = CTX_W'(ctx);
        bus.wb_data_in  = dat;
        @(posedge clka); #1;
        bus.wb_valid_in = 1'b0;
    endtask

    task automatic issue(input logic [2:0] mask, input int ctx, input logic [ADDR_W-1:0] tgt,
                         input bit exp_tk, input bit wb_en, input int wb_ctx,
                         input logic [DATA_W-1:0] wb_dat, input string nm);
        int n;
        bus.br_valid_in  = 1'b1;
        bus.br_mask_in   = mask;
        bus.br_ctx_in    = CTX_W'(ctx);
        bus.br_target_in = tgt;
        bus.wb_valid_in  = wb_en;
        bus.wb_ctx_in    = CTX_W'(wb_ctx);
        bus.wb_data_in   = wb_dat;
        @(posedge clka); #1;
        bus.br_valid_in = 1'b0;
        bus.wb_valid_in = 1'b0;
        n = 1;
        while (!bus.pc_ld_valid_out && n < 20) begin
            @(posedge clka); #1;
            n++;
        end
        chk({nm, "_latency"}, 64'(n), 64'(LAT));
        chk({nm, "_taken"}, 64'(bus.pc_ld_taken_out), 64'(exp_tk));
        chk({nm, "_target"}, 64'(bus.pc_target_out), 64'(tgt));
    endtask

    task automatic finish_hs(input string nm);
        bus.pc_ld_ready_in = 1'b1;
        @(posedge clka); #1;
        chk({nm, "_valid_drop"}, 64'(bus.pc_ld_valid_out), 64'd0);
        chk({nm, "_ready_back"}, 64'(bus.br_ready_out), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n_in          = 1'b0;
        bus.wb_valid_in     = 1'b0;
        bus.wb_data_in      = '0;
        bus.wb_ctx_in       = '0;
        bus.br_valid_in     = 1'b0;
        bus.br_mask_in      = '0;
        bus.br_ctx_in       = '0;
        bus.br_target_in    = '0;
        bus.pc_ld_ready_in  = 1'b1;

        @(posedge clka);
        mon_en = 1'b1;
        @(posedge clka); #1;
        reset_n_in = 1'b1;
        chk("rst_cc", 64'(cc_out), 64'h492);
        chk("rst_valid", 64'(bus.pc_ld_valid_out), 64'd0);
        chk("rst_cnt", 64'(taken_cnt_out), 64'd0);
        chk("rst_ready", 64'(bus.br_ready_out), 64'd1);

        wb1(0, 16'h8000);
        issue(3'b100, 0, 16'h1234, 1'b1, 1'b0, 0, 16'h0, "neg_taken");
        finish_hs("hs_neg");
        wb1(0, 16'h0000);
        issue(3'b100, 0, 16'h2222, 1'b0, 1'b0, 0, 16'h0, "zero_not_neg");
        finish_hs("hs_zero");

        wb1(0, 16'h0005);
        issue(3'b010, 0, 16'h3030, 1'b1, 1'b1, 0, 16'h0000, "same_cycle_wb");
        finish_hs("hs_same");

        bus.pc_ld_ready_in = 1'b0;
        issue(3'b111, 0, 16'habcd, 1'b1, 1'b0, 0, 16'h0, "hold");
        for (int k = 0; k < 5; k++) begin
            bus.wb_valid_in = (k == 2);
            bus.wb_ctx_in   = '0;
            bus.wb_data_in  = 16'h8000;
            @(posedge clka); #1;
            bus.wb_valid_in = 1'b0;
            chk("hold_valid", 64'(bus.pc_ld_valid_out), 64'd1);
            chk("hold_taken", 64'(bus.pc_ld_taken_out), 64'd1);
            chk("hold_target", 64'(bus.pc_target_out), 64'habcd);
            chk("hold_ready", 64'(bus.br_ready_out), 64'd0);
        end
        finish_hs("hold_release");
        chk("hold_state_idle", 64'(state_out), 64'd0);

        wb1(2, 16'h0005);
        issue(3'b001, 1, 16'h0101, 1'b0, 1'b0, 0, 16'h0, "ctx1_zero");
        finish_hs("hs_ctx1");
        issue(3'b001, 2, 16'h0202, 1'b1, 1'b0, 0, 16'h0, "ctx2_pos");
        finish_hs("hs_ctx2");
        issue(3'b000, 0, 16'h0404, 1'b0, 1'b0, 0, 16'h0, "mask_none");
        finish_hs("hs_m0");
        issue(3'b111, 3, 16'h0303, 1'b1, 1'b0, 0, 16'h0, "mask_all");
        finish_hs("hs_m7");
        issue(3'b111, 5, 16'h0505, 1'b0, 1'b0, 0, 16'h0, "ctx_out_of_range");
        finish_hs("hs_oor");
        wb1(6, 16'h0000);
        issue(3'b100, 0, 16'h0606, 1'b1, 1'b0, 0, 16'h0, "oor_wb_ignored");
        finish_hs("hs_oor_wb");

        reset_n_in = 1'b0;
        repeat (2) @(posedge clka);
        #1 reset_n_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            issue(3'b111, 0, ADDR_W'(16'h1000 + k), 1'b1, 1'b0, 0, 16'h0, "cnt_run");
            finish_hs("hs_cnt");
        end
        chk("cnt_wrap", 64'(taken_cnt_out), 64'd1);

        bus.pc_ld_ready_in = 1'b0;
        issue(3'b111, 0, 16'h7777, 1'b1, 1'b0, 0, 16'h0, "pre_reset");
        reset_n_in = 1'b0;
        @(posedge clka); #1;
        chk("midrst_valid", 64'(bus.pc_ld_valid_out), 64'd0);
        chk("midrst_cnt", 64'(taken_cnt_out), 64'd0);
        chk("midrst_state", 64'(state_out), 64'd0);
        reset_n_in = 1'b1;
        bus.pc_ld_ready_in = 1'b1;
        @(posedge clka); #1;
        chk("post_rst_ready", 64'(bus.br_ready_out), 64'd1);

        repeat (2) @(posedge clka);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
